caesar_symbol_source: RTL and testbench

//   Upstream stage of the Caesar cipher datapath. Paces plaintext symbols 0..25 at TICK_HZ.

---
 rtl/caesar_pkg.sv | 26 ++
 rtl/rate_tick_gen.sv | 33 +++
 rtl/caesar_symbol_source.sv | 137 +++++++++++++
 tb/tb_caesar_symbol_source.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caesar_pkg.sv
// Shared constants, state encoding and helpers for the Caesar symbol source.
// Symbol range is 0..SYM_MAX; keys saturate at SYM_MAX.
package caesar_pkg;

  localparam int SYM_MAX = 25;
  localparam int SYM_W   = 6;
  localparam int KEY_W   = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [SYM_W-1:0] sym_next(
    input logic [SYM_W-1:0] s
  );
    return (s == SYM_W'(SYM_MAX)) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [KEY_W-1:0] key_clamp(
    input logic [KEY_W-1:0] k
  );
    return (k > KEY_W'(SYM_MAX)) ? KEY_W'(SYM_MAX) : k;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running divider: counts 0..CLK_HZ/TICK_HZ-1 and pulses tick at the top.
// Ports: CLOCK_50 clock, rst async active-low reset, tick one-cycle pulse.
module rate_tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic CLOCK_50,
  input  logic rst,
  output logic tick
);

  localparam int TC = CLK_HZ / TICK_HZ - 1;
  localparam int W  = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] r_cnt;
  logic         w_tc;

  assign w_tc = (r_cnt == TC_V);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = w_tc;

endmodule

// File: rtl/caesar_symbol_source.sv
// Paces symbols 0..SYM_MAX to the cipher stage with synced/clamped key and mode.
// Ports: CLOCK_50, rst (async low), SW, ENCRYPT, out_ready in; out_valid,
// plaintext, key, encrypt, tick, overrun out. CAESAR_SRC_STEP_EN adds step_n.
module caesar_symbol_source
  import caesar_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [KEY_W-1:0] SW,
  input  logic             ENCRYPT,
  input  logic             out_ready,
`ifdef CAESAR_SRC_STEP_EN
  input  logic             step_n,
`endif
  output logic             out_valid,
  output logic [SYM_W-1:0] plaintext,
  output logic [KEY_W-1:0] key,
  output logic             encrypt,
  output logic             tick,
  output logic             overrun
);

  logic [KEY_W-1:0] r_sw_s1;
  logic [KEY_W-1:0] r_sw_s2;
  logic             r_enc_s1;
  logic             r_enc_s2;
  logic [SYM_W-1:0] r_sym;
  state_t           r_state;
  logic [SYM_W-1:0] r_pt;
  logic [KEY_W-1:0] r_key;
  logic             r_enc;
  logic             r_ovr;

  logic             w_tick;
  logic             w_load;
  logic [KEY_W-1:0] w_key;
  logic [SYM_W-1:0] w_sym_nx;

  rate_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .tick     (w_tick)
  );

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_enc_s1 <= 1'b0;
      r_enc_s2 <= 1'b0;
    end else begin
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      r_enc_s1 <= ENCRYPT;
      r_enc_s2 <= r_enc_s1;
    end
  end

`ifdef CAESAR_SRC_STEP_EN
  // Idle level of the button is high, so reset to 1 to avoid a fake edge.
  logic r_stp_s1;
  logic r_stp_s2;
  logic r_stp_d;
  logic w_step;

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_stp_s1 <= 1'b1;
      r_stp_s2 <= 1'b1;
      r_stp_d  <= 1'b1;
    end else begin
      r_stp_s1 <= step_n;
      r_stp_s2 <= r_stp_s1;
      r_stp_d  <= r_stp_s2;
    end
  end

  assign w_step = r_stp_d & ~r_stp_s2;
  assign w_load = w_tick | w_step;
`else
  assign w_load = w_tick;
`endif

  assign w_key    = key_clamp(r_sw_s2);
  assign w_sym_nx = sym_next(r_sym);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sym   <= '0;
      r_pt    <= '0;
      r_key   <= '0;
      r_enc   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_pt    <= r_sym;
            r_key   <= w_key;
            r_enc   <= r_enc_s2;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            r_sym <= w_sym_nx;
            // Back-to-back: reload with the advanced symbol, no idle gap.
            if (w_load) begin
              r_pt  <= w_sym_nx;
              r_key <= w_key;
              r_enc <= r_enc_s2;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_load) begin
            r_ovr <= 1'b1;
          end
        end
      endcase
    end
  end

  assign out_valid = (r_state == ST_SEND);
  assign plaintext = r_pt;
  assign key       = r_key;
  assign encrypt   = r_enc;
  assign tick      = w_tick;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_caesar_symbol_source.sv
// Directed scoreboard bench for caesar_symbol_source (CLK_HZ=10, TICK_HZ=1).
// Step-button checks use a second, slow-divider instance when enabled.
module tb_caesar_symbol_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sw = '0;
  logic       enc = 1'b0;
  logic       rdy = 1'b0;

  logic       out_valid;
  logic [5:0] plaintext;
  logic [4:0] key;
  logic       encrypt;
  logic       tick;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int hs = 0;
  logic [11:0] sbq[$];

  always #5 clk = ~clk;

  caesar_symbol_source #(
    .CLK_HZ  (10),
    .TICK_HZ (1)
  ) dut (
    .CLOCK_50  (clk),
    .rst       (rst_n),
    .SW        (sw),
    .ENCRYPT   (enc),
    .out_ready (rdy),
`ifdef CAESAR_SRC_STEP_EN
    .step_n    (1'b1),
`endif
    .out_valid (out_valid),
    .plaintext (plaintext),
    .key       (key),
    .encrypt   (encrypt),
    .tick      (tick),
    .overrun   (overrun)
  );

`ifdef CAESAR_SRC_STEP_EN
  logic       stp_n = 1'b1;
  logic       rdy2 = 1'b1;
  logic       v2;
  logic [5:0] pt2;
  logic [4:0] key2;
  logic       enc2;
  logic       tick2;
  logic       ovr2;

  caesar_symbol_source #(
    .CLK_HZ  (1000),
    .TICK_HZ (1)
  ) dut2 (
    .CLOCK_50  (clk),
    .rst       (rst_n),
    .SW        (sw),
    .ENCRYPT   (enc),
    .out_ready (rdy2),
    .step_n    (stp_n),
    .out_valid (v2),
    .plaintext (pt2),
    .key       (key2),
    .encrypt   (enc2),
    .tick      (tick2),
    .overrun   (ovr2)
  );
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] clampk(input int s);
    return (s > 25) ? 5'd25 : 5'(s);
  endfunction

  function automatic logic [11:0] pay(input int p, input int k,
                                      input logic e);
    return {6'(p), clampk(k), e};
  endfunction

  // Check a pending handshake, then advance one clock.
  task automatic cyc();
    if (out_valid && rdy) begin
      hs++;
      chk("sb_nonempty", 32'(sbq.size() > 0), 32'(1));
      if (sbq.size() > 0)
        chk("payload", 32'({plaintext, key, encrypt}),
            32'(sbq.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_hs(input int target, input int budget,
                        input string tag);
    int n;
    n = 0;
    while (hs < target && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(hs), 32'(target));
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(out_valid), 32'(1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs = 0;
  endtask

  initial begin
    int n;
    int nv;
    int nt;
    int first;

    // 1: free run, reset values, sequence 0..25,0
    sw = 5'd3;
    enc = 1'b1;
    rdy = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("reset_outs",
        32'({out_valid, plaintext, key, encrypt, tick, overrun}),
        32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++) sbq.push_back(pay(i % 26, 3, 1'b1));
    n = 0;
    nv = 0;
    nt = 0;
    first = -1;
    while (hs < 27 && n < 400) begin
      if (out_valid) nv++;
      if (tick) begin
        nt++;
        if (first < 0) first = n;
      end
      cyc();
      n++;
    end
    chk("t1_hs", 32'(hs), 32'(27));
    chk("t1_valid_cycles", 32'(nv), 32'(27));
    chk("t1_ticks", 32'(nt), 32'(27));
    chk("t1_first_tick", 32'(first), 32'(9));
    chk("t1_overrun", 32'(overrun), 32'(0));
    chk("t1_sb_drained", 32'(sbq.size()), 32'(0));

    // 2: key clamp and hold during SEND
    sw = 5'd31;
    sbq.push_back(pay(1, 31, 1'b1));
    run_hs(28, 30, "t2_key31");
    sw = 5'd7;
    sbq.push_back(pay(2, 7, 1'b1));
    run_hs(29, 30, "t2_key7");
    rdy = 1'b0;
    sbq.push_back(pay(3, 7, 1'b1));
    wait_valid(30, "t2_valid");
    sw = 5'd20;
    enc = 1'b0;
    repeat (4) cyc();
    chk("t2_hold", 32'({plaintext, key, encrypt}), 32'(pay(3, 7, 1'b1)));
    rdy = 1'b1;
    run_hs(30, 5, "t2_release");

    // 3: backpressure, dropped tick, no skipped symbol
    sw = 5'd7;
    enc = 1'b1;
    rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) sbq.push_back(pay(i, 7, 1'b1));
    run_hs(4, 60, "t3_pre");
    rdy = 1'b0;
    sbq.push_back(pay(4, 7, 1'b1));
    wait_valid(20, "t3_valid");
    for (int i = 0; i < 25; i++) begin
      if (i == 5) chk("t3_ovr_early", 32'(overrun), 32'(0));
      chk("t3_stall", 32'({out_valid, plaintext}), 32'({1'b1, 6'd4}));
      cyc();
    end
    chk("t3_ovr_set", 32'(overrun), 32'(1));
    rdy = 1'b1;
    run_hs(5, 3, "t3_accept4");
    sbq.push_back(pay(5, 7, 1'b1));
    run_hs(6, 20, "t3_next5");
    chk("t3_ovr_sticky", 32'(overrun), 32'(1));

    // 4: ready on the tick cycle with plaintext 25
    sw = 5'd10;
    enc = 1'b0;
    rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 25; i++) sbq.push_back(pay(i, 10, 1'b0));
    run_hs(25, 300, "t4_pre");
    rdy = 1'b0;
    sbq.push_back(pay(25, 10, 1'b0));
    sbq.push_back(pay(0, 10, 1'b0));
    wait_valid(20, "t4_valid");
    n = 0;
    while (!tick && n < 20) begin
      cyc();
      n++;
    end
    chk("t4_tick_seen", 32'(tick), 32'(1));
    rdy = 1'b1;
    cyc();
    chk("t4_b2b", 32'({out_valid, plaintext, overrun}),
        32'({1'b1, 6'd0, 1'b0}));
    cyc();
    chk("t4_hs", 32'(hs), 32'(27));

    // 5: async reset during SEND
    sw = 5'd5;
    enc = 1'b1;
    rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) sbq.push_back(pay(i, 5, 1'b1));
    run_hs(12, 200, "t5_pre");
    rdy = 1'b0;
    sbq.push_back(pay(12, 5, 1'b1));
    wait_valid(20, "t5_valid");
    chk("t5_pt12", 32'(plaintext), 32'(12));
    rst_n = 1'b0;
    #1;
    chk("t5_async_drop", 32'({out_valid, plaintext}), 32'(0));
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs = 0;
    rdy = 1'b1;
    sbq.push_back(pay(0, 5, 1'b1));
    run_hs(1, 20, "t5_first0");

`ifdef CAESAR_SRC_STEP_EN
    // 6: step button, one payload per press
    rdy = 1'b0;
    stp_n = 1'b1;
    do_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    for (int p = 0; p < 2; p++) begin
      stp_n = 1'b0;
      nv = 0;
      first = -1;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        #1;
        if (v2) begin
          nv++;
          first = int'(pt2);
        end
      end
      chk("t6_one_payload", 32'(nv), 32'(1));
      chk("t6_symbol", 32'(first), 32'(p));
      stp_n = 1'b1;
      repeat (5) begin
        @(posedge clk);
        #1;
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
